// File: rtl/floating_divide.sv
// IEEE-754 single-precision divider: restoring mantissa division, one quotient bit per cycle,
// fixed 27-cycle latency from the accepting edge to the done pulse. Truncating, denormals flushed.
module floating_divide (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] out,
   output logic        busy,
   output logic        done,
   output logic        divByZero
);

   typedef enum logic [1:0] {IDLE, UNPACK, DIVIDE, NORMALIZE} state_t;

   state_t             state_reg;
   logic [31:0]        a_reg, b_reg;
   logic [23:0]        mant_a_reg, mant_b_reg;
   logic signed [9:0]  exp_reg;
   logic               sign_reg;
   logic               special_reg;
   logic [31:0]        special_val_reg;
   logic               dbz_reg;
   logic [24:0]        rem_reg;
   logic [24:0]        q_reg;
   logic [4:0]         count_reg;

   // Operand 0 is the dividend, operand 1 the divisor.
   logic [31:0] opnd [2];
   logic [1:0]  is_zero, is_inf;
   logic [23:0] mant [2];
   logic [7:0]  expo [2];

   assign opnd[0] = a_reg;
   assign opnd[1] = b_reg;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
         assign expo[gi]    = opnd[gi][30:23];
         assign is_zero[gi] = (opnd[gi][30:23] == 8'h00);
         assign is_inf[gi]  = (opnd[gi][30:23] == 8'hFF);
         assign mant[gi]    = {~is_zero[gi], opnd[gi][22:0]};
      end
   endgenerate

   logic        sign_calc;
   logic [24:0] mant_b_ext;
   logic        rem_ge;
   logic signed [9:0] exp_adj;
   logic [22:0] frac_sel;

   assign sign_calc  = a_reg[31] ^ b_reg[31];
   assign mant_b_ext = {1'b0, mant_b_reg};
   assign rem_ge     = (rem_reg >= mant_b_ext);
   assign exp_adj    = exp_reg - (q_reg[24] ? 10'sd0 : 10'sd1);
   assign frac_sel   = q_reg[24] ? q_reg[23:1] : q_reg[22:0];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg       <= IDLE;
         out             <= 32'h0000_0000;
         busy            <= 1'b0;
         done            <= 1'b0;
         divByZero       <= 1'b0;
         count_reg       <= 5'd0;
         a_reg           <= 32'h0;
         b_reg           <= 32'h0;
         mant_a_reg      <= 24'h0;
         mant_b_reg      <= 24'h0;
         exp_reg         <= 10'sd0;
         sign_reg        <= 1'b0;
         special_reg     <= 1'b0;
         special_val_reg <= 32'h0;
         dbz_reg         <= 1'b0;
         rem_reg         <= 25'h0;
         q_reg           <= 25'h0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  a_reg     <= a;
                  b_reg     <= b;
                  busy      <= 1'b1;
                  state_reg <= UNPACK;
               end
            end
            UNPACK: begin
               mant_a_reg <= mant[0];
               mant_b_reg <= mant[1];
               rem_reg    <= {1'b0, mant[0]};
               q_reg      <= 25'h0;
               count_reg  <= 5'd0;
               sign_reg   <= sign_calc;
               exp_reg    <= $signed({2'b00, expo[0]}) - $signed({2'b00, expo[1]}) + 10'sd127;
               dbz_reg    <= is_zero[1];
               // Special-case priority: NaN, divide-by-zero, infinite dividend, zero result.
               special_reg <= 1'b1;
               if ((is_zero[0] && is_zero[1]) || (is_inf[0] && is_inf[1]))
                  special_val_reg <= 32'h7FC0_0000;
               else if (is_zero[1] || is_inf[0])
                  special_val_reg <= {sign_calc, 8'hFF, 23'h0};
               else if (is_zero[0] || is_inf[1])
                  special_val_reg <= {sign_calc, 31'h0};
               else begin
                  special_reg     <= 1'b0;
                  special_val_reg <= 32'h0;
               end
               state_reg <= DIVIDE;
            end
            DIVIDE: begin
               q_reg   <= {q_reg[23:0], rem_ge};
               rem_reg <= (rem_ge ? (rem_reg - mant_b_ext) : rem_reg) << 1;
               if (count_reg == 5'd24) begin
                  count_reg <= 5'd0;
                  state_reg <= NORMALIZE;
               end else begin
                  count_reg <= count_reg + 5'd1;
               end
            end
            NORMALIZE: begin
               if (special_reg)
                  out <= special_val_reg;
               else if (exp_adj >= 10'sd255)
                  out <= {sign_reg, 8'hFF, 23'h0};
               else if (exp_adj <= 10'sd0)
                  out <= {sign_reg, 31'h0};
               else
                  out <= {sign_reg, exp_adj[7:0], frac_sel};
               divByZero <= dbz_reg;
               done      <= 1'b1;
               busy      <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/floating_divide.md
FLOATING_DIVIDE -- requirements
Module: floating_divide

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-004 SHALL have port: a  input  32  IEEE-754 single dividend; captured when start is accepted.
REQ-005 SHALL have port: b  input  32  IEEE-754 single divisor; captured when start is accepted.
REQ-006 SHALL have port: out  output  32  quotient a/b, registered.
REQ-007 SHALL have port: busy  output  1  high while an operation is in flight.
REQ-008 SHALL have port: done  output  1  one-cycle pulse; out valid from that cycle until the next done.
REQ-009 SHALL have port: divByZero  output  1  registered with out; high when b is zero.

Function
REQ-010 SHALL implement states IDLE, UNPACK, DIVIDE, NORMALIZE; IDLE->UNPACK on start, UNPACK->DIVIDE, DIVIDE->NORMALIZE after 25 iterations, NORMALIZE->IDLE.
REQ-011 SHALL capture a and b at the accepting edge N; later changes to a, b or start SHALL be ignored until the return to IDLE.
REQ-012 SHALL assert busy from the cycle after edge N through the cycle ending at edge N+27 inclusive.
REQ-013 SHALL assert done for exactly the one cycle after edge N+27 and SHALL update out and divByZero at that edge; fixed 27-cycle latency for every operand class.
REQ-014 start asserted in the done cycle SHALL be accepted (back-to-back); start while busy SHALL be dropped.
REQ-015 UNPACK SHALL form 24-bit mantissas with hidden 1 and 8-bit exponents; exponent 0 SHALL be treated as zero (denormals flushed); exponent 255 SHALL be treated as infinity.
REQ-016 DIVIDE SHALL be restoring division, one quotient bit per cycle, MSB first, yielding a 25-bit quotient q of mantA/mantB with binary point after q[24].
REQ-017 result exponent SHALL be computed as 10-bit signed expA - expB + 127, then decremented by 1 when q[24] is 0.
REQ-018 NORMALIZE SHALL take fraction q[23:1] when q[24] is 1, else q[22:0]; rounding SHALL be truncation.
REQ-019 final exponent >= 255 SHALL give signed infinity (exp 255, fraction 0); final exponent <= 0 SHALL give signed zero.
REQ-020 sign SHALL be a[31] XOR b[31] for all results except NaN.
REQ-021 special cases, by priority: 0/0 or inf/inf -> 0x7FC00000; x/0 -> signed infinity with divByZero 1; inf/x -> signed infinity; 0/x or x/inf -> signed zero.
REQ-022 divByZero SHALL be 1 exactly when b is zero, including 0/0; otherwise 0.

Reset
REQ-023 reset_n low at a rising edge SHALL force state IDLE, out 0x00000000, busy 0, done 0, divByZero 0, iteration counter 0.
REQ-024 reset SHALL take priority over start and abort any operation in flight; no done SHALL be produced for the aborted operation.
REQ-025 start sampled on the same edge that reset_n is low SHALL be ignored.

Verification
REQ-026 a=0x40C00000 (6.0), b=0x40000000 (2.0), start for one cycle -> done exactly 27 cycles later, out=0x40400000, divByZero 0.
REQ-027 a=0x3F800000, b=0x40400000 -> out=0x3EAAAAAA (truncated); a=0xC1000000, b=0x3F000000 -> out=0xC1800000.
REQ-028 a=0x3F800000, b=0x00000000 -> out=0x7F800000, divByZero 1; a=0, b=0 -> out=0x7FC00000, divByZero 1.
REQ-029 a=0x7F000000, b=0x00800000 -> out=0x7F800000; a=0x00800000, b=0x7F000000 -> out=0x00000000.
REQ-030 reset_n low for one cycle at cycle 10 of an operation -> busy 0 next cycle, no done pulse, out=0x00000000; new start afterwards completes normally.
REQ-031 start held high continuously with changing operands -> done every 28 cycles; each out matches the operands present at its accepting edge.
